// File: rtl/hex_digit_counter_if.sv
// hex_digit_counter_if
//   Groups the board-facing signals of the hex digit counter.
//   Clock and reset stay plain ports on the design.
//
//   step_n    raw pushbutton, active-low, asynchronous (KEY[1])
//   load_n    raw pushbutton, active-low, asynchronous (KEY[2])
//   load_val  value loaded on a load press (SW[3:0])
//   run       1 = count on prescaler ticks (SW[9])
//   up        1 = increment, 0 = decrement (SW[8])
//   digit     current digit, feeds the 7-segment decoder
//   carry     one-cycle pulse on wrap in either direction
//   tick      one-cycle prescaler pulse (LEDR heartbeat)
//
//   master: board / stimulus side.  slave: the counter.
interface hex_digit_counter_if;
  logic       step_n;
  logic       load_n;
  logic [3:0] load_val;
  logic       run;
  logic       up;
  logic [3:0] digit;
  logic       carry;
  logic       tick;

  modport master (
    output step_n, load_n, load_val, run, up,
    input  digit, carry, tick
  );

  modport slave (
    input  step_n, load_n, load_val, run, up,
    output digit, carry, tick
  );
endinterface

// File: rtl/hex_digit_counter.sv
// hex_digit_counter
//   Front end for the HEX0 display: conditions the two raw pushbuttons
//   (2-flop sync, debounce, falling-edge detect) and keeps a wrap-around
//   digit that steps on a button press or a prescaled run-mode tick, with
//   parallel load from the switches.
//
//   CLOCK_50  in   system clock, all state on the rising edge
//   resetn    in   asynchronous active-low reset
//   bus       slave side of hex_digit_counter_if (buttons, switches,
//             digit / carry / tick outputs)
module hex_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int MAX_VAL         = 15
) (
  input logic                CLOCK_50,
  input logic                resetn,
  hex_digit_counter_if.slave bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    MAX_D   = 4'(MAX_VAL);

  // Button index 0 = step, 1 = load.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    armed;
  logic [1:0]    press;
  logic [1:0]    primed;
  logic [DW-1:0] db_cnt [2];

  logic [TW-1:0] pre_cnt;
  logic          tick_q;

  logic [3:0]    digit_q;
  logic          carry_q;
  logic [3:0]    load_clamped;
  logic          count_ev;

  assign btn_raw = {bus.load_n, bus.step_n};

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // primed[1] rises once sync2 holds a genuine pin sample rather than the
  // reset value; arming waits for it so a button held through reset
  // cannot masquerade as a fresh press.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      primed <= 2'b00;
    end else begin
      primed <= {primed[0], 1'b1};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      stable <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A button only becomes armed after it has been seen released and
  // settled; press pulses need an armed button.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      stable_d <= 2'b11;
      armed    <= 2'b00;
      press    <= 2'b00;
    end else begin
      stable_d <= stable;
      press    <= armed & stable_d & ~stable;
      armed    <= armed | ({2{primed[1]}} & sync2 & stable);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (!bus.run) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (pre_cnt == TK_LAST) begin
      pre_cnt <= '0;
      tick_q  <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick_q  <= 1'b0;
    end
  end

  assign load_clamped = (bus.load_val > MAX_D) ? MAX_D : bus.load_val;
  // Step and tick in the same cycle merge into a single count.
  assign count_ev     = press[0] | tick_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      digit_q <= 4'd0;
      carry_q <= 1'b0;
    end else if (press[1]) begin
      digit_q <= load_clamped;
      carry_q <= 1'b0;
    end else if (count_ev) begin
      if (bus.up) begin
        if (digit_q == MAX_D) begin
          digit_q <= 4'd0;
          carry_q <= 1'b1;
        end else begin
          digit_q <= digit_q + 4'd1;
          carry_q <= 1'b0;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_q <= MAX_D;
          carry_q <= 1'b1;
        end else begin
          digit_q <= digit_q - 4'd1;
          carry_q <= 1'b0;
        end
      end
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.digit = digit_q;
  assign bus.carry = carry_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter
//   Directed bench for hex_digit_counter with DEBOUNCE_CYCLES=4,
//   TICK_CYCLES=8. Two instances run side by side on the same inputs:
//   dut15 (MAX_VAL=15) and dut9 (MAX_VAL=9). Expected digit changes are
//   queued when stimulus is applied and checked when a digit changes or
//   carry is seen, including the clock edge on which it happens.
`timescale 1ns/1ps
module tb_hex_digit_counter;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  hex_digit_counter_if bus15();
  hex_digit_counter_if bus9();

  assign bus9.step_n   = bus15.step_n;
  assign bus9.load_n   = bus15.load_n;
  assign bus9.load_val = bus15.load_val;
  assign bus9.run      = bus15.run;
  assign bus9.up       = bus15.up;

  hex_digit_counter #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8), .MAX_VAL(15)) dut15 (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus15)
  );

  hex_digit_counter #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8), .MAX_VAL(9)) dut9 (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus9)
  );

  typedef struct {
    logic [3:0] digit;
    logic       carry;
    int         cyc;
  } ev_t;

  ev_t        q15[$];
  ev_t        q9[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [3:0] exp15;
  logic [3:0] exp9;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t model_count(input logic [3:0] d, input logic u, input int mx, input int stamp);
    ev_t e;
    e.cyc   = stamp;
    e.carry = 1'b0;
    if (u) begin
      if (d == 4'(mx)) begin e.digit = 4'd0; e.carry = 1'b1; end
      else e.digit = 4'(d + 4'd1);
    end else begin
      if (d == 4'd0) begin e.digit = 4'(mx); e.carry = 1'b1; end
      else e.digit = 4'(d - 4'd1);
    end
    return e;
  endfunction

  task automatic push_count(input int stamp);
    ev_t e;
    e = model_count(exp15, bus15.up, 15, stamp); exp15 = e.digit; q15.push_back(e);
    e = model_count(exp9,  bus15.up, 9,  stamp); exp9  = e.digit; q9.push_back(e);
  endtask

  task automatic push_load(input logic [3:0] v, input int stamp);
    ev_t e;
    e.carry = 1'b0;
    e.cyc   = stamp;
    exp15 = v;
    exp9  = (v > 4'd9) ? 4'd9 : v;
    e.digit = exp15; q15.push_back(e);
    e.digit = exp9;  q9.push_back(e);
  endtask

  task automatic check_ev(input string tag, input logic [3:0] d, input logic c, input bit have, input ev_t e);
    chk({tag, "_expected"}, 32'(have), 32'd1);
    if (have) begin
      chk({tag, "_digit"}, 32'(d), 32'(e.digit));
      chk({tag, "_carry"}, 32'(c), 32'(e.carry));
      chk({tag, "_cycle"}, cyc, e.cyc);
    end
  endtask

  task automatic monitor();
    logic [3:0] l15;
    logic [3:0] l9;
    ev_t        e;
    bit         have;
    l15 = 4'd0;
    l9  = 4'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        l15 = bus15.digit;
        l9  = bus9.digit;
      end else begin
        if (bus15.digit !== l15 || bus15.carry !== 1'b0) begin
          have = (q15.size() != 0);
          if (have) e = q15.pop_front();
          check_ev("ev15", bus15.digit, bus15.carry, have, e);
          l15 = bus15.digit;
        end
        if (bus9.digit !== l9 || bus9.carry !== 1'b0) begin
          have = (q9.size() != 0);
          if (have) e = q9.pop_front();
          check_ev("ev9", bus9.digit, bus9.carry, have, e);
          l9 = bus9.digit;
        end
      end
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step_edge();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q15.size() != 0 || q9.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(q15.size() + q9.size()), 32'd0);
  endtask

  // Pin edge right after edge p: update lands on edge p+8
  // (2 sync + 4 debounce + 1 edge detect, then the digit register).
  task automatic press_step(input int hold);
    step_edge();
    bus15.step_n = 1'b0;
    push_count(cyc + 8);
    cycles(hold);
    bus15.step_n = 1'b1;
  endtask

  task automatic press_load(input logic [3:0] v, input int hold);
    step_edge();
    bus15.load_val = v;
    bus15.load_n   = 1'b0;
    push_load(v, cyc + 8);
    cycles(hold);
    bus15.load_n = 1'b1;
  endtask

  initial begin
    int r0;
    int c0;
    bus15.step_n   = 1'b0;
    bus15.load_n   = 1'b1;
    bus15.load_val = 4'd0;
    bus15.run      = 1'b0;
    bus15.up       = 1'b1;
    exp15 = 4'd0;
    exp9  = 4'd0;
    #1 resetn = 1'b0;
    fork monitor(); join_none
    #22;
    chk("reset_digit15", 32'(bus15.digit), 32'd0);
    chk("reset_carry15", 32'(bus15.carry), 32'd0);
    chk("reset_tick15",  32'(bus15.tick),  32'd0);
    chk("reset_digit9",  32'(bus9.digit),  32'd0);

    // Release reset with step held: no event may follow.
    @(negedge clk) resetn = 1'b1;
    cycles(30);
    chk("held_through_reset", 32'(bus15.digit), 32'd0);
    bus15.step_n = 1'b1;
    cycles(20);
    chk("held_release_no_event", 32'(bus15.digit), 32'd0);

    // Three clean presses: 1, 2, 3.
    repeat (3) begin
      press_step(20);
      wait_drain("press_drain", 40);
      cycles(10);
    end

    // Bounce shorter than the debounce window, then a clean press.
    step_edge(); bus15.step_n = 1'b0;
    step_edge(); step_edge(); bus15.step_n = 1'b1;
    step_edge(); bus15.step_n = 1'b0;
    step_edge(); step_edge(); bus15.step_n = 1'b1;
    cycles(20);
    chk("bounce_no_change", 32'(bus15.digit), 32'd3);
    press_step(20);
    wait_drain("bounce_clean_drain", 40);
    cycles(10);

    // Load 14 (dut9 clamps to 9), then run mode up across the wrap.
    press_load(4'd14, 20);
    wait_drain("load14_drain", 40);
    cycles(10);
    step_edge();
    bus15.run = 1'b1;
    r0 = cyc;
    push_count(r0 + 9);
    push_count(r0 + 17);
    for (int k = 1; k <= 16; k++) begin
      step_edge();
      chk("tick_period", 32'(bus15.tick), 32'((k == 8) || (k == 16)));
    end
    step_edge();
    bus15.run = 1'b0;
    wait_drain("run_drain", 40);
    cycles(10);

    // Count down from 0: dut15 wraps to 15 with carry, dut9 goes 1 -> 0.
    bus15.up = 1'b0;
    cycles(2);
    press_step(20);
    wait_drain("down_wrap_drain", 40);
    cycles(10);

    // Load 12: dut9 clamps to 9.
    press_load(4'd12, 20);
    wait_drain("load12_drain", 40);
    cycles(10);

    // Load and step debounced in the same cycle: load wins.
    bus15.up = 1'b1;
    step_edge();
    bus15.load_val = 4'd5;
    bus15.step_n   = 1'b0;
    bus15.load_n   = 1'b0;
    push_load(4'd5, cyc + 8);
    cycles(20);
    bus15.step_n = 1'b1;
    bus15.load_n = 1'b1;
    wait_drain("load_vs_step_drain", 40);
    cycles(10);

    // Step press pulse and the first tick land on the same cycle.
    step_edge();
    bus15.run = 1'b1;
    r0 = cyc;
    step_edge();
    bus15.step_n = 1'b0;
    push_count(r0 + 9);
    push_count(r0 + 17);
    while (cyc < r0 + 17) step_edge();
    bus15.run    = 1'b0;
    bus15.step_n = 1'b1;
    wait_drain("step_tick_drain", 40);
    cycles(10);

    // Reset while running, in the cycle tick is high.
    step_edge();
    bus15.run = 1'b1;
    r0 = cyc;
    push_count(r0 + 9);
    while (cyc < r0 + 16) step_edge();
    chk("pre_reset_tick", 32'(bus15.tick), 32'd1);
    chk("pre_reset_queue", 32'(q15.size() + q9.size()), 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("midrun_reset_digit15", 32'(bus15.digit), 32'd0);
    chk("midrun_reset_tick15",  32'(bus15.tick),  32'd0);
    chk("midrun_reset_carry15", 32'(bus15.carry), 32'd0);
    chk("midrun_reset_digit9",  32'(bus9.digit),  32'd0);
    exp15 = 4'd0;
    exp9  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    c0 = cyc;
    push_count(c0 + 9);
    for (int k = 1; k <= 8; k++) begin
      step_edge();
      chk("post_reset_tick", 32'(bus15.tick), 32'(k == 8));
    end
    step_edge();
    bus15.run = 1'b0;
    wait_drain("post_reset_drain", 40);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
